// File: rtl/fetch_if.sv
// Instruction-fetch bus bundle: memory request/response, datapath redirect and
// the instruction handoff to decode.
//   master : the fetch unit (drives requests and the instruction output)
//   slave  : the environment (instruction memory plus datapath)
interface fetch_if;
  // Request channel to instruction memory
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;

  // In-order response channel from instruction memory
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;

  // Taken branch/jump from the datapath
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  // Instruction handoff to the datapath
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data,
    input  redirect_valid,
    input  redirect_pc,
    output inst_valid,
    output inst_out,
    output inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data,
    output redirect_valid,
    output redirect_pc,
    input  inst_valid,
    input  inst_out,
    input  inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Prefetching instruction fetch unit.
// Issues word-aligned requests from a fetch PC, tracks in-flight requests with
// an in-order pc queue, buffers returned instructions in a DEPTH-entry FIFO and
// hands them to the datapath. A redirect flushes the FIFO, retargets the fetch
// PC and marks every in-flight response for discard.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - fetch_if.master: imem_req_*, imem_resp_*, redirect_*, inst_*
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic clk,
  input  logic rst,
  fetch_if.master bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  // Architectural state
  logic [31:0]      fetch_pc;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop_count;
  logic [PTR_W-1:0] fifo_rd_ptr;
  logic [PTR_W-1:0] fifo_wr_ptr;
  logic [PTR_W-1:0] pcq_rd_ptr;
  logic [PTR_W-1:0] pcq_wr_ptr;
  entry_t           fifo_mem [DEPTH];
  logic [31:0]      pcq_mem  [DEPTH];

  // Next-state values
  logic [31:0]      fetch_pc_nxt;
  logic [CNT_W-1:0] fifo_count_nxt;
  logic [CNT_W-1:0] outstanding_nxt;
  logic [CNT_W-1:0] drop_count_nxt;
  logic [PTR_W-1:0] fifo_rd_ptr_nxt;
  logic [PTR_W-1:0] fifo_wr_ptr_nxt;
  logic [PTR_W-1:0] pcq_rd_ptr_nxt;
  logic [PTR_W-1:0] pcq_wr_ptr_nxt;

  // Per-cycle events
  logic             req_valid_c;
  logic             credit_ok;
  logic             issue;
  logic             resp;
  logic             redirect;
  logic             push;
  logic             pop;
  logic             fifo_nonempty;
  logic [SUM_W-1:0] in_use;

  // Event decode. Credits count buffered plus in-flight words (including
  // ones already marked for discard), so every response always has a slot.
  always_comb begin
    in_use        = SUM_W'(fifo_count) + SUM_W'(outstanding);
    credit_ok     = in_use < SUM_W'(DEPTH);
    redirect      = bus.redirect_valid;
    req_valid_c   = !rst && !redirect && credit_ok;
    issue         = req_valid_c && bus.imem_req_ready;
    resp          = bus.imem_resp_valid;
    fifo_nonempty = fifo_count != '0;
    push          = resp && (drop_count == '0) && !redirect;
    pop           = fifo_nonempty && bus.inst_ready && !redirect;
  end

  // Next-state logic; redirect overrides every FIFO and PC update
  always_comb begin
    fetch_pc_nxt    = fetch_pc;
    fifo_count_nxt  = fifo_count;
    drop_count_nxt  = drop_count;
    fifo_rd_ptr_nxt = fifo_rd_ptr;
    fifo_wr_ptr_nxt = fifo_wr_ptr;
    pcq_rd_ptr_nxt  = pcq_rd_ptr;
    pcq_wr_ptr_nxt  = pcq_wr_ptr;
    outstanding_nxt = outstanding + CNT_W'(issue) - CNT_W'(resp);

    // The pc queue shadows outstanding requests, dropped or not
    if (issue) pcq_wr_ptr_nxt = pcq_wr_ptr + PTR_W'(1);
    if (resp)  pcq_rd_ptr_nxt = pcq_rd_ptr + PTR_W'(1);

    if (redirect) begin
      // Everything still in flight after this edge belongs to the old path
      fetch_pc_nxt    = bus.redirect_pc & 32'hFFFF_FFFC;
      fifo_count_nxt  = '0;
      fifo_wr_ptr_nxt = fifo_rd_ptr;
      drop_count_nxt  = outstanding_nxt;
    end else begin
      if (issue) fetch_pc_nxt = fetch_pc + 32'd4;
      if (resp && (drop_count != '0)) drop_count_nxt = drop_count - CNT_W'(1);
      if (push) fifo_wr_ptr_nxt = fifo_wr_ptr + PTR_W'(1);
      if (pop)  fifo_rd_ptr_nxt = fifo_rd_ptr + PTR_W'(1);
      fifo_count_nxt = fifo_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      fifo_count  <= '0;
      outstanding <= '0;
      drop_count  <= '0;
      fifo_rd_ptr <= '0;
      fifo_wr_ptr <= '0;
      pcq_rd_ptr  <= '0;
      pcq_wr_ptr  <= '0;
    end else begin
      fetch_pc    <= fetch_pc_nxt;
      fifo_count  <= fifo_count_nxt;
      outstanding <= outstanding_nxt;
      drop_count  <= drop_count_nxt;
      fifo_rd_ptr <= fifo_rd_ptr_nxt;
      fifo_wr_ptr <= fifo_wr_ptr_nxt;
      pcq_rd_ptr  <= pcq_rd_ptr_nxt;
      pcq_wr_ptr  <= pcq_wr_ptr_nxt;
    end
  end

  // Address of each issued request, consumed in response order
  always_ff @(posedge clk) begin
    if (issue) pcq_mem[pcq_wr_ptr] <= fetch_pc;
  end

  // Instruction FIFO storage; reset loads a NOP at RESET_PC so the head
  // presents a benign instruction while empty after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_mem[PTR_W'(i)] <= '{pc: RESET_PC, inst: NOP};
      end
    end else if (push) begin
      fifo_mem[fifo_wr_ptr] <= '{pc: pcq_mem[pcq_rd_ptr], inst: bus.imem_resp_data};
    end
  end

  // Outputs
  always_comb begin
    bus.imem_req_valid = req_valid_c;
    bus.imem_req_addr  = fetch_pc;
    bus.inst_valid     = !rst && fifo_nonempty;
    bus.inst_out       = fifo_mem[fifo_rd_ptr].inst;
    bus.inst_pc        = fifo_mem[fifo_rd_ptr].pc;
  end

  // Internal invariants guaranteed by the credit rule
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (push && !pop) |-> (fifo_count < CNT_W'(DEPTH)));
  a_outstanding_bound: assert property (@(posedge clk) disable iff (rst)
    outstanding <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-configurable in-order memory model,
// a request-address checker, and a scoreboard of expected {pc, inst} pairs
// filled at each stream start and drained by a monitor on every consume.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_if bus ();
  fetch_if wbus ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Second instance only exercises fetch-PC wraparound
  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (wbus)
  );

  int tests = 0;
  int fails = 0;
  int pops  = 0;
  int fires = 0;
  int mem_lat = 1;
  int cyc = 0;
  logic [31:0] exp_fetch_pc = 32'h0;
  logic [31:0] exp_q [$];

  typedef struct packed {
    int          due;
    logic [31:0] data;
  } mresp_t;
  mresp_t mq [$];

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_stream(input logic [31:0] pc);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(pc + 32'(4 * i));
    exp_fetch_pc = pc;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    exp_q.delete();
    tick();
    tick();
  endtask

  // Memory: accepted request returns inst_of(addr) mem_lat cycles later, in order
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      bus.imem_resp_valid <= 1'b0;
      bus.imem_resp_data  <= 32'h0;
    end else begin
      if (bus.imem_req_valid && bus.imem_req_ready)
        mq.push_back('{due: cyc + mem_lat, data: inst_of(bus.imem_req_addr)});
      if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
        bus.imem_resp_valid <= 1'b1;
        bus.imem_resp_data  <= mq[0].data;
        void'(mq.pop_front());
      end else begin
        bus.imem_resp_valid <= 1'b0;
      end
    end
    cyc = cyc + 1;
  end

  // Request checker: each accepted request must carry the next sequential address
  always @(negedge clk) begin
    if (!rst && bus.imem_req_valid && bus.imem_req_ready) begin
      check("req_addr", bus.imem_req_addr, exp_fetch_pc);
      exp_fetch_pc = exp_fetch_pc + 32'd4;
      fires++;
    end
  end

  // Scoreboard monitor: every consumed instruction matches the queue head
  always @(negedge clk) begin
    logic [31:0] pc;
    if (!rst && !bus.redirect_valid && bus.inst_valid && bus.inst_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got pc %h, expected no instruction", bus.inst_pc);
      end else begin
        pc = exp_q.pop_front();
        check("sb_pc", bus.inst_pc, pc);
        check("sb_inst", bus.inst_out, inst_of(pc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    int f0;
    logic [15:0] pat;
    logic [31:0] wexp [4];
    wexp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    pat  = 16'b1011_0110_1110_0101;

    rst = 1'b1;
    bus.imem_req_ready  = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.inst_ready      = 1'b0;
    wbus.imem_req_ready  = 1'b1;
    wbus.imem_resp_valid = 1'b0;
    wbus.imem_resp_data  = 32'h0;
    wbus.redirect_valid  = 1'b0;
    wbus.redirect_pc     = 32'h0;
    wbus.inst_ready      = 1'b0;
    tick();
    tick();

    // Reset state
    @(negedge clk);
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    check("rst_inst_out", bus.inst_out, 32'h0000_0013);
    check("rst_inst_pc", bus.inst_pc, 32'h0000_0000);
    check("rst_wrap_inst_pc", wbus.inst_pc, 32'hFFFF_FFF8);
    tick();

    // Streaming with 1-cycle memory; first instruction valid in cycle 3
    bus.imem_req_ready = 1'b1;
    bus.inst_ready = 1'b1;
    mem_lat = 1;
    start_stream(32'h0);
    p0 = pops;
    rst = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c <= 3) check($sformatf("a_inst_valid_c%0d", c), 32'(bus.inst_valid), 32'(c == 3));
      if (c <= 4) begin
        check($sformatf("wrap_req_valid_c%0d", c), 32'(wbus.imem_req_valid), 32'd1);
        check($sformatf("wrap_req_addr_c%0d", c), wbus.imem_req_addr, wexp[c-1]);
      end else if (c <= 6) begin
        check($sformatf("wrap_req_valid_c%0d", c), 32'(wbus.imem_req_valid), 32'd0);
      end
      tick();
    end
    check("a_pops", 32'(pops - p0), 32'd10);

    // Back-pressure: exactly DEPTH requests, then one per pop
    apply_reset();
    bus.inst_ready = 1'b0;
    mem_lat = 1;
    start_stream(32'h0);
    f0 = fires;
    rst = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    @(negedge clk);
    check("b_fires_full", 32'(fires - f0), 32'd4);
    check("b_req_valid_full", 32'(bus.imem_req_valid), 32'd0);
    check("b_inst_valid_full", 32'(bus.inst_valid), 32'd1);
    check("b_head_pc", bus.inst_pc, 32'h0);
    tick();
    bus.inst_ready = 1'b1;
    f0 = fires;
    tick();
    bus.inst_ready = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("b_fires_per_pop", 32'(fires - f0), 32'd1);
    for (int i = 0; i < 16; i++) begin
      bus.inst_ready = pat[i];
      tick();
    end

    // Memory stall: request held stable, no duplicate issue
    apply_reset();
    bus.imem_req_ready = 1'b0;
    bus.inst_ready = 1'b1;
    mem_lat = 1;
    start_stream(32'h0);
    f0 = fires;
    p0 = pops;
    rst = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check($sformatf("c_req_valid_c%0d", c), 32'(bus.imem_req_valid), 32'd1);
      check($sformatf("c_req_addr_c%0d", c), bus.imem_req_addr, 32'h0);
      tick();
    end
    check("c_no_fire_stalled", 32'(fires - f0), 32'd0);
    bus.imem_req_ready = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    check("c_pops", 32'(pops - p0), 32'd8);

    // Redirect with 3 requests outstanding
    apply_reset();
    mem_lat = 4;
    bus.imem_req_ready = 1'b1;
    bus.inst_ready = 1'b1;
    start_stream(32'h0);
    rst = 1'b0;
    tick();
    tick();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0102;
    start_stream(32'h0000_0100);
    @(negedge clk);
    check("d_req_valid_redirect", 32'(bus.imem_req_valid), 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    check("d_req_valid_after", 32'(bus.imem_req_valid), 32'd1);
    check("d_req_addr_after", bus.imem_req_addr, 32'h0000_0100);
    p0 = pops;
    for (int k = 0; k < 20 && pops == p0; k++) tick();
    check("d_first_inst_seen", 32'(pops != p0), 32'd1);
    for (int k = 0; k < 6; k++) tick();

    // Second redirect while drops are still pending
    apply_reset();
    mem_lat = 4;
    start_stream(32'h0);
    rst = 1'b0;
    tick();
    tick();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0102;
    start_stream(32'h0000_0100);
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0203;
    start_stream(32'h0000_0200);
    tick();
    bus.redirect_valid = 1'b0;
    p0 = pops;
    for (int k = 0; k < 20 && pops == p0; k++) tick();
    check("d2_first_inst_seen", 32'(pops != p0), 32'd1);
    for (int k = 0; k < 6; k++) tick();

    // Reset mid-stream with two buffered entries
    apply_reset();
    mem_lat = 1;
    bus.inst_ready = 1'b0;
    start_stream(32'h0);
    rst = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("e_inst_valid_pre", 32'(bus.inst_valid), 32'd1);
    tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    start_stream(32'h0);
    @(negedge clk);
    check("e_inst_valid", 32'(bus.inst_valid), 32'd0);
    check("e_inst_out", bus.inst_out, 32'h0000_0013);
    check("e_inst_pc", bus.inst_pc, 32'h0000_0000);
    check("e_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("e_req_addr", bus.imem_req_addr, 32'h0000_0000);
    tick();
    bus.inst_ready = 1'b1;
    p0 = pops;
    for (int k = 0; k < 8; k++) tick();
    check("e_pops", 32'(pops - p0), 32'd7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4, instruction queue entries; power of two, 2..16.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request present.
REQ-006 SHALL have port imem_req_addr  output  32  word-aligned fetch address.
REQ-007 SHALL have port imem_req_ready  input  1  memory accepts request this cycle.
REQ-008 SHALL have port imem_resp_valid  input  1  instruction word returned; responses in request order.
REQ-009 SHALL have port imem_resp_data  input  32  returned instruction word.
REQ-010 SHALL have port redirect_valid  input  1  branch/jump taken by the datapath; restart fetch.
REQ-011 SHALL have port redirect_pc  input  32  new fetch target.
REQ-012 SHALL have port inst_valid  output  1  inst_out/inst_pc hold a valid instruction.
REQ-013 SHALL have port inst_out  output  32  instruction to the datapath (decoder, imm_gen, control unit).
REQ-014 SHALL have port inst_pc  output  32  address of inst_out.
REQ-015 SHALL have port inst_ready  input  1  datapath consumes inst_out this cycle.

Function
REQ-016 SHALL hold a fetch PC register, a FIFO of DEPTH {pc, inst} entries, an outstanding-request counter, and a drop counter, each wide enough to hold 0..DEPTH.
REQ-017 SHALL assert imem_req_valid only when fifo_count + outstanding < DEPTH; imem_req_addr = fetch PC.
REQ-018 SHALL treat a request as issued when imem_req_valid & imem_req_ready; fetch PC += 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0); outstanding += 1.
REQ-019 SHALL decrement outstanding on every imem_resp_valid; issue and response in the same cycle leave outstanding unchanged.
REQ-020 SHALL, when imem_resp_valid and drop counter = 0, write {pc, imem_resp_data} into the FIFO; the pc is taken from an internal in-order pc queue matching issued requests.
REQ-021 SHALL, when imem_resp_valid and drop counter > 0, discard the response and decrement the drop counter.
REQ-022 SHALL drive inst_valid = (fifo_count > 0) and present the FIFO head on inst_out/inst_pc; pop when inst_valid & inst_ready.
REQ-023 SHALL allow FIFO push and pop in the same cycle, including when full (credit rule REQ-017 guarantees no overflow) and when empty (no bypass: data appears the following cycle).
REQ-024 SHALL have fetch latency: response accepted in cycle N gives inst_valid in cycle N+1 if the FIFO was empty.
REQ-025 SHALL, on redirect_valid, in the same edge: flush the FIFO (count := 0); set fetch PC := {redirect_pc[31:2], 2'b00}; set drop counter := outstanding + issued-this-cycle - (resp_valid this cycle); suppress any pop effect.
REQ-026 SHALL not assert imem_req_valid in the redirect cycle; new-target requests start the next cycle.
REQ-027 SHALL give redirect priority over all other events; redirect while drop counter > 0 adds to, never loses, pending drops.
REQ-028 SHALL keep imem_req_addr and imem_req_valid stable while imem_req_valid & !imem_req_ready, unless redirect_valid.

Reset
REQ-029 SHALL, while rst = 1, set fetch PC := RESET_PC, FIFO count, outstanding, and drop counter := 0; imem_req_valid = 0, inst_valid = 0, inst_out = 32'h0000_0013 (NOP), inst_pc = RESET_PC.
REQ-030 SHALL ignore responses, redirects, and inst_ready during rst; reset mid-operation abandons in-flight requests; memory is reset alongside.
REQ-031 SHALL issue the first request to RESET_PC in the first cycle after rst deasserts.

Verification
REQ-032 Reset then memory with ready = 1 and 1-cycle response: requests 0,4,8,C; inst_pc 0,4,8,C in order; inst_valid at cycle 3 after reset release.
REQ-033 inst_ready = 0 held: exactly DEPTH = 4 requests issued, then imem_req_valid = 0; raising inst_ready resumes one request per pop.
REQ-034 Redirect to 32'h0000_0102 with 3 requests outstanding: next request address 0x100; the 3 old responses are dropped; the first inst_pc after redirect is 0x100.
REQ-035 imem_req_ready held at 0 for 5 cycles: imem_req_addr stable for 5 cycles, no duplicate issue.
REQ-036 Push and pop in the same cycle with FIFO full and with FIFO empty: count unchanged / correct; RESET_PC = 32'hFFFF_FFF8 wraps fetch to 0x0.
REQ-037 Assert rst mid-stream with FIFO at 2 entries: next cycle inst_valid = 0, inst_out = 32'h13, fetch restarts at RESET_PC.
